// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lif_pkg
// Purpose  : Shared types and arithmetic helpers for the LIF neuron array.
//            Holds the sweep FSM state encoding, a saturating adder and the
//            shift-based threshold adaptation rules. The helpers work on
//            32-bit containers so that one definition serves every W <= 31.
// Revision : 1.0  initial release
// ============================================================================
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lif_state_e;

  // min(a + b, 2^w - 1); the sum is formed one bit wider than the operands
  // so that it cannot wrap before the comparison.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] sum;
    logic [31:0] cap;
    cap = (32'd1 << w) - 32'd1;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, cap}) return cap;
    return sum[31:0];
  endfunction

  // Spike rule: thr + (thr >> shift), clamped at ceil_val.
  function automatic logic [31:0] thr_adapt_up(input logic [31:0] thr,
                                               input int          shift,
                                               input logic [31:0] ceil_val);
    logic [32:0] sum;
    sum = {1'b0, thr} + {1'b0, (thr >> shift)};
    if (sum > {1'b0, ceil_val}) return ceil_val;
    return sum[31:0];
  endfunction

  // No-spike rule: step down by max(thr >> shift, 1) but never below
  // floor_val; a threshold already at or under the floor is held.
  function automatic logic [31:0] thr_adapt_dn(input logic [31:0] thr,
                                               input int          shift,
                                               input logic [31:0] floor_val);
    logic [31:0] dec;
    dec = thr >> shift;
    if (dec == 32'd0) dec = 32'd1;
    if (thr <= floor_val) return thr;
    // Comparing against the headroom avoids an underflowing subtraction.
    if (dec >= (thr - floor_val)) return floor_val;
    return thr - dec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lif_core.sv
`default_nettype none
// ============================================================================
// Module   : lif_core
// Purpose  : Purely combinational single-neuron leaky integrate-and-fire
//            update with adaptive threshold and refractory counter.
// Ports    : v, thr, r, cur          - stored state and input current
//            v_next, thr_next, r_next - updated state
//            spike                    - neuron fired this step
// Revision : 1.0  initial release
// ============================================================================
module lif_core
  import lif_pkg::*;
#(
  parameter int W              = 8,
  parameter int LEAK_SHIFT     = 3,
  parameter int THR_MIN        = 8,
  parameter int THR_MAX        = 255,
  parameter int ADAPT_UP_SHIFT = 2,
  parameter int ADAPT_DN_SHIFT = 5,
  parameter int REFRACT        = 2,
  parameter int RW             = 2
) (
  input  logic [W-1:0]  v,
  input  logic [W-1:0]  thr,
  input  logic [RW-1:0] r,
  input  logic [W-1:0]  cur,
  output logic [W-1:0]  v_next,
  output logic [W-1:0]  thr_next,
  output logic [RW-1:0] r_next,
  output logic          spike
);

  logic [W-1:0] w_leaked;
  logic [31:0]  w_integ;

  // v - (v >> k) never exceeds v, so the leak cannot underflow in W bits.
  assign w_leaked = v - (v >> LEAK_SHIFT);
  assign w_integ  = sat_add(32'(w_leaked), 32'(cur), W);

  always_comb begin
    v_next   = '0;
    thr_next = W'(thr_adapt_dn(32'(thr), ADAPT_DN_SHIFT, 32'(THR_MIN)));
    r_next   = r;
    spike    = 1'b0;
    if (r != '0) begin
      // Refractory: membrane clamped to zero, threshold keeps decaying.
      r_next = r - RW'(1);
    end else if (w_integ >= 32'(thr)) begin
      // Fire against the pre-update threshold, then raise it.
      spike    = 1'b1;
      r_next   = RW'(REFRACT);
      thr_next = W'(thr_adapt_up(32'(thr), ADAPT_UP_SHIFT, 32'(THR_MAX)));
    end else begin
      v_next = W'(w_integ);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lif_array.sv
`default_nettype none
// ============================================================================
// Module   : lif_array
// Purpose  : Time-multiplexed array of N leaky integrate-and-fire neurons
//            sharing one lif_core. A step pulse snapshots the current vector
//            and sweeps neurons 0..N-1, one per cycle, then publishes the
//            spike vector alongside a one-cycle done pulse.
// Ports    : clk, rst_n      - clock, synchronous active-low reset
//            step_i          - start a timestep sweep (accepted in IDLE)
//            current_i       - packed currents, neuron k at [k*W +: W]
//            busy_o          - sweep in progress
//            done_o          - one-cycle pulse, sweep complete
//            spikes_o        - spike vector of the last completed step
//            overrun_o       - one-cycle pulse, step_i seen while not IDLE
//            probe_idx_i     - debug neuron select
//            probe_v_o/thr_o - membrane / threshold of selected neuron
// Revision : 1.0  initial release
// ============================================================================
module lif_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS      = 4,
  parameter int W              = 8,
  parameter int LEAK_SHIFT     = 3,
  parameter int THR_INIT       = 100,
  parameter int THR_MIN        = 8,
  parameter int THR_MAX        = (2 ** W) - 1,
  parameter int ADAPT_UP_SHIFT = 2,
  parameter int ADAPT_DN_SHIFT = 5,
  parameter int REFRACT        = 2,
  localparam int c_idx_w       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   step_i,
  input  logic [N_NEURONS*W-1:0] current_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [N_NEURONS-1:0]   spikes_o,
  output logic                   overrun_o,
  input  logic [c_idx_w-1:0]     probe_idx_i,
  output logic [W-1:0]           probe_v_o,
  output logic [W-1:0]           probe_thr_o
);

  localparam int c_rw = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_NEURONS - 1);

  lif_state_e r_state;
  lif_state_e w_state_next;

  logic [c_idx_w-1:0]   r_idx;
  logic [W-1:0]         r_v   [N_NEURONS];
  logic [W-1:0]         r_thr [N_NEURONS];
  logic [c_rw-1:0]      r_ref [N_NEURONS];
  logic [W-1:0]         r_cur [N_NEURONS];
  logic [N_NEURONS-1:0] r_pending;
  logic [N_NEURONS-1:0] r_spikes;
  logic                 r_overrun;

  logic [W-1:0]         w_v_next;
  logic [W-1:0]         w_thr_next;
  logic [c_rw-1:0]      w_ref_next;
  logic                 w_spike;
  logic [N_NEURONS-1:0] w_pending_next;
  logic                 w_last;
  logic                 w_probe_ok;

  assign w_last = (r_idx == c_last_idx);

  // --------------------------------------------------------------------------
  // Sweep FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (step_i) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shared update datapath, fed by the neuron currently addressed by r_idx
  // --------------------------------------------------------------------------
  lif_core #(
    .W              (W),
    .LEAK_SHIFT     (LEAK_SHIFT),
    .THR_MIN        (THR_MIN),
    .THR_MAX        (THR_MAX),
    .ADAPT_UP_SHIFT (ADAPT_UP_SHIFT),
    .ADAPT_DN_SHIFT (ADAPT_DN_SHIFT),
    .REFRACT        (REFRACT),
    .RW             (c_rw)
  ) u_core (
    .v        (r_v[r_idx]),
    .thr      (r_thr[r_idx]),
    .r        (r_ref[r_idx]),
    .cur      (r_cur[r_idx]),
    .v_next   (w_v_next),
    .thr_next (w_thr_next),
    .r_next   (w_ref_next),
    .spike    (w_spike)
  );

  always_comb begin
    w_pending_next        = r_pending;
    w_pending_next[r_idx] = w_spike;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        r_v[k]   <= '0;
        r_thr[k] <= W'(THR_INIT);
        r_ref[k] <= '0;
        r_cur[k] <= '0;
      end
      r_idx     <= '0;
      r_pending <= '0;
      r_spikes  <= '0;
      r_overrun <= 1'b0;
    end else begin
      // Steps arriving in RUN or DONE are dropped but flagged.
      r_overrun <= step_i && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (step_i) begin
            // Shadow copy: the sweep is immune to current_i changing mid-run.
            for (int k = 0; k < N_NEURONS; k++) begin
              r_cur[k] <= current_i[k*W +: W];
            end
            r_idx     <= '0;
            r_pending <= '0;
          end
        end
        ST_RUN: begin
          r_v[r_idx]   <= w_v_next;
          r_thr[r_idx] <= w_thr_next;
          r_ref[r_idx] <= w_ref_next;
          r_pending    <= w_pending_next;
          if (w_last) begin
            // Publish on the final update so spikes_o is valid with done_o.
            r_spikes <= w_pending_next;
          end else begin
            r_idx <= r_idx + c_idx_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o    = (r_state == ST_RUN);
  assign done_o    = (r_state == ST_DONE);
  assign spikes_o  = r_spikes;
  assign overrun_o = r_overrun;

  // Out-of-range selects (non power-of-two N) read as zero.
  assign w_probe_ok  = (32'(probe_idx_i) < N_NEURONS);
  assign probe_v_o   = w_probe_ok ? r_v[probe_idx_i]   : '0;
  assign probe_thr_o = w_probe_ok ? r_thr[probe_idx_i] : '0;

endmodule
`default_nettype wire

// File: tb/tb_lif_array.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lif_array
// Purpose  : Directed self-checking bench for lif_array. A second instance
//            with REFRACT=0 exercises the threshold ceiling.
// Revision : 1.0  initial release
// ============================================================================
module tb_lif_array;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           step_i = 1'b0;
  logic [N*W-1:0] current_i = '0;
  logic           busy_o, done_o, overrun_o;
  logic [N-1:0]   spikes_o;
  logic [1:0]     probe_idx_i = '0;
  logic [W-1:0]   probe_v_o, probe_thr_o;

  logic           step2 = 1'b0;
  logic [N*W-1:0] cur2 = '0;
  logic           busy2, done2, overrun2;
  logic [N-1:0]   spikes2;
  logic [1:0]     pidx2 = '0;
  logic [W-1:0]   pv2, pthr2;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  lif_array u_dut (
    .clk(clk), .rst_n(rst_n), .step_i(step_i), .current_i(current_i),
    .busy_o(busy_o), .done_o(done_o), .spikes_o(spikes_o),
    .overrun_o(overrun_o), .probe_idx_i(probe_idx_i),
    .probe_v_o(probe_v_o), .probe_thr_o(probe_thr_o)
  );

  lif_array #(.REFRACT(0)) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .step_i(step2), .current_i(cur2),
    .busy_o(busy2), .done_o(done2), .spikes_o(spikes2),
    .overrun_o(overrun2), .probe_idx_i(pidx2),
    .probe_v_o(pv2), .probe_thr_o(pthr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; step_i = 1'b0; step2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_probe(input string tag, input int k, input int ev, input int ethr);
    probe_idx_i = 2'(k);
    #1;
    chk($sformatf("%s_v%0d", tag, k), 32'(probe_v_o), ev);
    chk($sformatf("%s_thr%0d", tag, k), 32'(probe_thr_o), ethr);
  endtask

  // One full sweep on the main instance; optionally scrambles current_i
  // while the sweep runs. Leaves the bench 1 ns after the edge into IDLE.
  task automatic do_step(input bit scramble);
    int c;
    logic [N*W-1:0] saved;
    @(negedge clk);
    step_i = 1'b1;
    @(posedge clk); #1;
    step_i = 1'b0;
    saved = current_i;
    if (scramble) current_i = ~current_i;
    c = 1;
    while (!done_o && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("step_latency", c, 5);
    current_i = saved;
    @(posedge clk); #1;
  endtask

  task automatic do_step2();
    int c;
    @(negedge clk);
    step2 = 1'b1;
    @(posedge clk); #1;
    step2 = 1'b0;
    c = 1;
    while (!done2 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("nr_latency", c, 5);
    @(posedge clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev0 [6] = '{20, 38, 54, 68, 80, 0};
    int et0 [6] = '{97, 94, 92, 90, 88, 110};
    int es0 [6] = '{0, 0, 0, 0, 0, 1};
    int es1 [4] = '{2, 0, 0, 2};
    int et1 [4] = '{125, 122, 119, 148};
    int etc [5] = '{125, 156, 195, 243, 255};
    logic [N-1:0] spk_or;
    logic         spk_and;
    int  prev_thr, mono_bad, cyc, n_done, n_ov;
    int  done_at [4];

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_spikes", 32'(spikes_o), 0);
    chk("rst_overrun", 32'(overrun_o), 0);
    for (int k = 0; k < N; k++) chk_probe("rst", k, 0, 100);

    // ---------------- I0=20 on neuron 0, scrambled mid-sweep ----------------
    current_i = {8'd0, 8'd0, 8'd0, 8'd20};
    for (int s = 0; s < 6; s++) begin
      do_step(s[0]);
      chk($sformatf("n0_spikes_s%0d", s + 1), 32'(spikes_o), es0[s]);
      chk_probe($sformatf("n0_s%0d", s + 1), 0, ev0[s], et0[s]);
    end
    chk_probe("n3_s6", 3, 0, 86);
    do_step(1'b0);
    chk("n0_spikes_s7", 32'(spikes_o), 0);
    chk_probe("n0_s7", 0, 0, 107);

    // ---------------- I1=255 with refractory ----------------
    do_reset();
    current_i = {8'd0, 8'd0, 8'd255, 8'd0};
    for (int s = 0; s < 4; s++) begin
      do_step(1'b0);
      chk($sformatf("n1_spikes_s%0d", s + 1), 32'(spikes_o), es1[s]);
      chk_probe($sformatf("n1_s%0d", s + 1), 1, 0, et1[s]);
    end

    // ---------------- zero current, 200 steps ----------------
    do_reset();
    current_i = '0;
    spk_or = '0; mono_bad = 0; prev_thr = 100;
    for (int s = 0; s < 200; s++) begin
      do_step(1'b0);
      spk_or |= spikes_o;
      probe_idx_i = 2'(s % N);
      #1;
      if (s >= N && int'(probe_thr_o) > prev_thr && (s % N) == 0) mono_bad++;
      if ((s % N) == 0) prev_thr = int'(probe_thr_o);
    end
    chk("decay_no_spikes", 32'(spk_or), 0);
    chk("decay_monotonic", mono_bad, 0);
    for (int k = 0; k < N; k++) chk_probe("decay", k, 0, 8);

    // ---------------- threshold ceiling, REFRACT=0 ----------------
    cur2 = {N{8'd255}};
    spk_and = 1'b1;
    for (int s = 0; s < 20; s++) begin
      do_step2();
      spk_and &= &spikes2;
      pidx2 = 2'(s % N);
      #1;
      chk($sformatf("ceil_thr_s%0d", s + 1), 32'(pthr2), (s < 5) ? etc[s] : 255);
    end
    chk("ceil_all_spike", 32'(spk_and), 1);
    chk("ceil_v", 32'(pv2), 0);

    // ---------------- step_i held high ----------------
    do_reset();
    @(negedge clk);
    step_i = 1'b1;
    cyc = 0; n_done = 0; n_ov = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        chk("held_busy_c1", 32'(busy_o), 1);
        chk("held_ovr_c1", 32'(overrun_o), 0);
      end
      if (done_o) begin
        if (n_done < 4) done_at[n_done] = cyc;
        n_done++;
      end
      if (overrun_o) n_ov++;
    end
    step_i = 1'b0;
    chk("held_done_count", n_done, 4);
    chk("held_first_done", (n_done > 0) ? done_at[0] : -1, 5);
    chk("held_period_a", (n_done > 1) ? done_at[1] - done_at[0] : -1, 6);
    chk("held_period_b", (n_done > 3) ? done_at[3] - done_at[2] : -1, 6);
    chk("held_overruns", n_ov, 20);
    repeat (3) @(posedge clk);
    #1;

    // ---------------- reset mid-sweep ----------------
    do_reset();
    current_i = {N{8'd255}};
    do_step(1'b0);
    chk("abort_pre_spikes", 32'(spikes_o), 32'hF);
    @(negedge clk);
    step_i = 1'b1;
    @(posedge clk); #1;
    step_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_busy_idx2", 32'(busy_o), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_done", 32'(done_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_spikes", 32'(spikes_o), 0);
    for (int k = 0; k < N; k++) chk_probe("abort", k, 0, 100);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done_o) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    current_i = {8'd0, 8'd0, 8'd0, 8'd20};
    do_step(1'b0);
    chk("post_spikes", 32'(spikes_o), 0);
    chk_probe("post", 0, 20, 97);
    chk_probe("post", 1, 0, 97);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
